can_tx_scheduler: RTL and testbench

- Shares the single user TX packet interface of the CAN packet-level controller (tx_start/tx_data/tx_done/tx_acked) between NUM_REQ requesters.
- Round-robin grant, one outstanding frame at a time.
- Retries frames that are not ACKed, and aborts any attempt that never completes within a cycle budget.
- Sits between user logic and the packet controller in the same clock domain.

---
 rtl/can_tx_scheduler.sv | 146 ++++++++++++++
 tb/tb_can_tx_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: round-robin sharing of one CAN TX packet port.
// Retries NACKed frames after a gap; aborts a request on timeout.
module can_tx_scheduler #(
   parameter int          NUM_REQ     = 4,
   parameter int          MAX_RETRY   = 3,
   parameter logic [15:0] GAP_CYC     = 16'd1000,
   parameter logic [31:0] TIMEOUT_CYC = 32'd2000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [32*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     rsp_done,
   output logic [1:0]             rsp_status,
   output logic                   busy,
   output logic                   tx_start,
   output logic [31:0]            tx_data,
   input  logic                   tx_done,
   input  logic                   tx_acked
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, SEND, GAP, REPORT} state_t;

   state_t        state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] owner;
   logic [3:0]    retry_cnt;
   logic [15:0]   gap_cnt;
   logic [31:0]   timer;

   logic          sel_found;
   logic [PW-1:0] sel_idx;
   logic [PW:0]   probe;
   logic [PW-1:0] rr_next;
   logic [31:0]   timer_inc;
   logic          timed_out;
   logic          last_gap;
   logic          retry_left;

   assign timer_inc  = (timer == '1) ? timer : timer + 32'd1;
   assign timed_out  = (timer >= TIMEOUT_CYC - 32'd1);
   assign last_gap   = (gap_cnt >= GAP_CYC - 16'd1);
   assign retry_left = (retry_cnt < 4'(MAX_RETRY));
   assign rr_next    = (sel_idx == PW'(NUM_REQ - 1)) ?
                       '0 : sel_idx + 1'b1;

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      probe     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         probe = {1'b0, rr_ptr} + (PW+1)'(i);
         if (probe >= (PW+1)'(NUM_REQ))
            probe = probe - (PW+1)'(NUM_REQ);
         if (req_valid[probe[PW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = probe[PW-1:0];
         end
      end
   end

   // Request FSM: accept, launch, retry gap, report; all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         retry_cnt  <= '0;
         gap_cnt    <= '0;
         timer      <= '0;
         req_ready  <= '0;
         rsp_done   <= '0;
         rsp_status <= 2'b00;
         busy       <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= '0;
      end else begin
         req_ready <= '0;
         rsp_done  <= '0;
         unique case (state)
            IDLE: begin
               if (sel_found) begin
                  req_ready <= ONE << sel_idx;
                  tx_data   <= req_data[32*sel_idx +: 32];
                  owner     <= sel_idx;
                  rr_ptr    <= rr_next;
                  retry_cnt <= '0;
                  timer     <= '0;
                  busy      <= 1'b1;
                  tx_start  <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               timer <= timer_inc;
               if (tx_done) begin
                  tx_start <= 1'b0;
                  if (tx_acked) begin
                     rsp_status <= 2'b00;
                     rsp_done   <= ONE << owner;
                     state      <= REPORT;
                  end else if (retry_left) begin
                     retry_cnt <= retry_cnt + 4'd1;
                     gap_cnt   <= '0;
                     state     <= GAP;
                  end else begin
                     rsp_status <= 2'b01;
                     rsp_done   <= ONE << owner;
                     state      <= REPORT;
                  end
               end else if (timed_out) begin
                  tx_start   <= 1'b0;
                  rsp_status <= 2'b10;
                  rsp_done   <= ONE << owner;
                  state      <= REPORT;
               end
            end
            GAP: begin
               timer <= timer_inc;
               if (timed_out) begin
                  rsp_status <= 2'b10;
                  rsp_done   <= ONE << owner;
                  state      <= REPORT;
               end else if (last_gap) begin
                  tx_start <= 1'b1;
                  state    <= SEND;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end
            REPORT: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb_can_tx_scheduler: directed checks of grant order, retry,
// timeout and reset behaviour of can_tx_scheduler.
module tb_can_tx_scheduler;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [32*N-1:0] req_data = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   rsp_done;
   logic [1:0]     rsp_status;
   logic           busy;
   logic           tx_start;
   logic [31:0]    tx_data;
   logic           tx_done = 1'b0;
   logic           tx_acked = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   can_tx_scheduler #(
      .NUM_REQ     (N),
      .MAX_RETRY   (3),
      .GAP_CYC     (16'd4),
      .TIMEOUT_CYC (32'd100)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .rsp_done   (rsp_done),
      .rsp_status (rsp_status),
      .busy       (busy),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_done    (tx_done),
      .tx_acked   (tx_acked)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Grant to requester g with every frame ACKed; enter from IDLE.
   task automatic serve(input int g);
      tick();
      check("rr_ready", 32'(req_ready), 32'(1) << g);
      check("rr_data", tx_data, 32'h1000_0000 + 32'(g));
      tx_done = 1'b1; tx_acked = 1'b1;
      tick();
      tx_done = 1'b0; tx_acked = 1'b0;
      check("rr_done", 32'(rsp_done), 32'(1) << g);
      check("rr_status", 32'(rsp_status), 32'd0);
      tick();
      check("rr_idle_busy", 32'(busy), 32'd0);
   endtask

   // Launch for requester 2, NACK attempts until ack_at (4 = never).
   task automatic retry_run(input int ack_at, input logic [1:0] st,
                            input logic [3:0] rc);
      req_valid = 4'b0100;
      tick();
      check("rt_ready", 32'(req_ready), 32'h4);
      req_valid = '0;
      for (int a = 0; a < 4; a++) begin
         check("rt_launch", 32'(tx_start), 32'd1);
         check("rt_data", tx_data, 32'h1000_0002);
         tx_done = 1'b1; tx_acked = (a == ack_at);
         tick();
         tx_done = 1'b0; tx_acked = 1'b0;
         if (a == ack_at || a == 3) break;
         for (int k = 0; k < 4; k++) begin
            check("rt_gap", 32'(tx_start), 32'd0);
            tick();
         end
      end
      check("rt_done", 32'(rsp_done), 32'h4);
      check("rt_status", 32'(rsp_status), 32'(st));
      check("rt_cnt", 32'(dut.retry_cnt), 32'(rc));
      tick();
   endtask

   initial begin
      tick();
      tick();
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_done", 32'(rsp_done), 32'd0);
      check("rst_status", 32'(rsp_status), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_start", 32'(tx_start), 32'd0);
      check("rst_data", tx_data, 32'd0);
      rst = 1'b0;

      // Single ACKed frame.
      req_data[31:0] = 32'hDEADBEEF;
      req_valid = 4'b0001;
      tick();
      check("s_ready", 32'(req_ready), 32'h1);
      check("s_start", 32'(tx_start), 32'd1);
      check("s_data", tx_data, 32'hDEADBEEF);
      check("s_busy", 32'(busy), 32'd1);
      req_valid = '0;
      tick();
      check("s_ready_pulse", 32'(req_ready), 32'd0);
      repeat (48) tick();
      check("s_hold", 32'(tx_start), 32'd1);
      tx_done = 1'b1; tx_acked = 1'b1;
      tick();
      tx_done = 1'b0; tx_acked = 1'b0;
      check("s_drop", 32'(tx_start), 32'd0);
      check("s_done", 32'(rsp_done), 32'h1);
      check("s_status", 32'(rsp_status), 32'd0);
      check("s_busy_rep", 32'(busy), 32'd1);
      tick();
      check("s_done_pulse", 32'(rsp_done), 32'd0);
      check("s_busy_low", 32'(busy), 32'd0);

      // Round robin from a fresh reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++)
         req_data[32*i +: 32] = 32'h1000_0000 + 32'(i);
      req_valid = 4'b1111;
      serve(0); serve(1); serve(2); serve(3); serve(0); serve(1);
      req_valid = 4'b1011;
      serve(3); serve(0); serve(1);
      req_valid = '0;
      tick();

      // Retries exhausted, then ACK on the third attempt.
      retry_run(4, 2'b01, 4'd3);
      retry_run(2, 2'b00, 4'd2);

      // Timeout with no tx_done.
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      repeat (99) tick();
      check("to_last", 32'(tx_start), 32'd1);
      tick();
      check("to_drop", 32'(tx_start), 32'd0);
      check("to_done", 32'(rsp_done), 32'h1);
      check("to_status", 32'(rsp_status), 32'h2);
      tick();

      // tx_done+ACK on the final cycle wins over timeout.
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      repeat (99) tick();
      tx_done = 1'b1; tx_acked = 1'b1;
      tick();
      tx_done = 1'b0; tx_acked = 1'b0;
      check("tie_done", 32'(rsp_done), 32'h1);
      check("tie_status", 32'(rsp_status), 32'd0);
      tick();

      // NACK on the final cycle: gap entered, then timeout in GAP.
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      repeat (99) tick();
      tx_done = 1'b1; tx_acked = 1'b0;
      tick();
      tx_done = 1'b0;
      check("gto_nodone", 32'(rsp_done), 32'd0);
      check("gto_start", 32'(tx_start), 32'd0);
      tick();
      check("gto_done", 32'(rsp_done), 32'h1);
      check("gto_status", 32'(rsp_status), 32'h2);
      tick();

      // Stale tx_done in IDLE.
      tx_done = 1'b1; tx_acked = 1'b1;
      tick();
      tx_done = 1'b0; tx_acked = 1'b0;
      check("stale_done", 32'(rsp_done), 32'd0);
      check("stale_busy", 32'(busy), 32'd0);
      tick();
      check("stale_done2", 32'(rsp_done), 32'd0);
      check("stale_start", 32'(tx_start), 32'd0);

      // Reset in the middle of SEND.
      req_valid = 4'b0010;
      tick();
      check("mr_start", 32'(tx_start), 32'd1);
      req_valid = '0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      check("mr_start0", 32'(tx_start), 32'd0);
      check("mr_busy0", 32'(busy), 32'd0);
      check("mr_done0", 32'(rsp_done), 32'd0);
      rst = 1'b0;
      req_valid = 4'b1111;
      tick();
      check("mr_first", 32'(req_ready), 32'h1);
      check("mr_nodone", 32'(rsp_done), 32'd0);
      req_valid = '0;
      tx_done = 1'b1; tx_acked = 1'b1;
      tick();
      tx_done = 1'b0; tx_acked = 1'b0;
      check("mr_done", 32'(rsp_done), 32'h1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
